// File: rtl/redirect_flush_ctrl.sv
// ============================================================================
// Module   : redirect_flush_ctrl
// Brief    : Redirect/flush sequencer with bubble-shadow tracking and a
//            non-nesting interrupt latch. The optional perf counters are
//            enabled with REDIRECT_PERF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module redirect_flush_ctrl #(
    parameter int SHADOW_DEPTH = 2,
    parameter int PC_SEL_W     = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                intr,
    input  logic                mie,
    input  logic                ex_valid,
    input  logic                stall,
    input  logic                mret_ex,
    input  logic [PC_SEL_W-1:0] pc_sel_ex,
    output logic                int_taken,
    output logic                flushed,
    output logic                flush_if_id,
    output logic                flush_id_ex,
    output logic                redirect,
`ifdef REDIRECT_PERF_EN
    output logic [31:0]         redirect_cnt,
    output logic [15:0]         int_cnt,
`endif
    output logic                in_isr
);

    localparam int         c_CNT_W  = $clog2(SHADOW_DEPTH + 1);
    localparam logic [0:0] S_RUN    = 1'b0;
    localparam logic [0:0] S_SHADOW = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_sh_cnt;
    logic [c_CNT_W-1:0] w_sh_cnt_nxt;
    logic               r_pend;
    logic               r_in_isr;
    logic               w_run;
    logic               w_int_taken;
    logic               w_redirect;

    assign w_run       = (r_state == S_RUN);
    assign w_int_taken = w_run & r_pend & ex_valid & ~stall & ~r_in_isr;
    assign w_redirect  = w_run & ~stall & (w_int_taken | (pc_sel_ex != '0));

    assign int_taken   = w_int_taken;
    assign redirect    = w_redirect;
    assign flush_if_id = w_redirect;
    assign flush_id_ex = w_redirect;
    assign flushed     = (r_state == S_SHADOW);
    assign in_isr      = r_in_isr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_RUN;
            r_sh_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sh_cnt <= w_sh_cnt_nxt;
        end
    end

    // The shadow counter only advances on unstalled cycles, because a stalled
    // EX stage still holds the same bubble.
    always_comb begin
        w_state_nxt  = r_state;
        w_sh_cnt_nxt = r_sh_cnt;
        case (r_state)
            S_RUN: begin
                if (w_redirect) begin
                    w_state_nxt  = S_SHADOW;
                    w_sh_cnt_nxt = c_CNT_W'(SHADOW_DEPTH - 1);
                end
            end
            S_SHADOW: begin
                if (!stall) begin
                    if (r_sh_cnt == '0) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_sh_cnt_nxt = r_sh_cnt - 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt  = S_RUN;
                w_sh_cnt_nxt = '0;
            end
        endcase
    end

    // Requests arriving inside a handler are dropped, so nesting never occurs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pend   <= 1'b0;
            r_in_isr <= 1'b0;
        end else begin
            if (w_int_taken || !mie) begin
                r_pend <= 1'b0;
            end else begin
                r_pend <= r_pend | (intr & ~r_in_isr);
            end

            if (w_int_taken) begin
                r_in_isr <= 1'b1;
            end else if (mret_ex && w_run && ex_valid && !stall) begin
                r_in_isr <= 1'b0;
            end
        end
    end

`ifdef REDIRECT_PERF_EN
    logic [31:0] r_redirect_cnt;
    logic [15:0] r_int_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_redirect_cnt <= '0;
            r_int_cnt      <= '0;
        end else begin
            if (w_redirect) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
            if (w_int_taken) begin
                r_int_cnt <= r_int_cnt + 16'd1;
            end
        end
    end

    assign redirect_cnt = r_redirect_cnt;
    assign int_cnt      = r_int_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/redirect_flush_ctrl.md
Name: redirect_flush_ctrl

Overview:
Pipeline control-flow sequencer for the pipelined MCU core. Watches the 3-bit PC select produced by the execute-stage branch-condition logic and generates IF/ID and ID/EX flushes. Tracks the bubble shadow and drives the `flushed` qualifier back into that logic. Latches, arbitrates and times the external interrupt, producing `int_taken` and tracking in-ISR state until `mret`.

Parameters:
SHADOW_DEPTH, 2, number of EX-stage cycles following a redirect that hold flushed bubbles (1..3)
PC_SEL_W, 3, width of the PC select bus

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous, active-high reset
intr  input  1  external interrupt request, level-sensitive
mie  input  1  global machine interrupt enable from CSR file
ex_valid  input  1  EX stage holds a real (non-bubble) instruction
stall  input  1  load-use stall from hazard unit; pipeline registers frozen this cycle
mret_ex  input  1  `mret` decoded in EX
pc_sel_ex  input  PC_SEL_W  PC select from execute-stage branch logic (0 = PC+4, 1 = jalr, 2 = branch, 3 = jal, 4 = trap vector)
int_taken  output  1  take interrupt this cycle (combinational from registered state)
flushed  output  1  instruction in EX is a flushed bubble; gates redirects
flush_if_id  output  1  clear IF/ID register at next edge
flush_id_ex  output  1  clear ID/EX register at next edge
redirect  output  1  pc_sel_ex != 0 and EX result honoured this cycle
in_isr  output  1  registered; interrupt handler active

Behaviour:
- Reset (RST high at an edge):
  - state = RUN; shadow count = 0; pend_q = 0; in_isr = 0.
  - All outputs low in the following cycle.
  - Reset mid-shadow or mid-pending discards both.
- States: RUN, SHADOW. Counter `sh_cnt` is ceil(log2(SHADOW_DEPTH+1)) bits.
- `flushed` = (state == SHADOW).
- Interrupt latch, each edge:
  - If `int_taken` is high: pend_q <= 0.
  - Otherwise: pend_q <= pend_q | (intr & mie & !in_isr).
  - `mie` falling clears pend_q at the next edge.
- `int_taken` = (state == RUN) & pend_q & ex_valid & !stall & !in_isr.
  - `int_taken` has priority over any pc_sel_ex value; external logic produces PC select 4.
- `redirect` = (state == RUN) & !stall & (int_taken | pc_sel_ex != 0).
- `flush_if_id` = `flush_id_ex` = `redirect`, same cycle (zero latency).
- Transitions:
  - RUN -> SHADOW when redirect; sh_cnt <= SHADOW_DEPTH-1.
  - In SHADOW with !stall: if sh_cnt == 0, go to RUN; else sh_cnt decrements.
  - In SHADOW with stall: state and sh_cnt hold.
  - pc_sel_ex is ignored in SHADOW (no new redirect, no flush).
- in_isr:
  - Set at the edge where int_taken = 1.
  - Cleared at the edge where mret_ex & (state == RUN) & ex_valid & !stall.
  - mret in a bubble or during stall has no effect.
- Simultaneous events:
  - int_taken and mret_ex in the same cycle: int_taken wins; in_isr stays 1.
  - New interrupt request while in_isr: not latched (nesting disabled).
  - stall and pc_sel_ex != 0 together: no redirect; re-evaluated when stall drops.
- SHADOW_DEPTH = 1: SHADOW lasts exactly one unstalled cycle.

Optional Feature:
REDIRECT_PERF_EN
- Defined:
  - Adds output `redirect_cnt [31:0]`, counting cycles where redirect = 1.
  - Adds output `int_cnt [15:0]`, counting int_taken.
  - Both reset to 0 on RST; both wrap modulo 2^N with no saturation.
- Undefined: both ports and all counter logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset, then pc_sel_ex = 2 for 1 cycle with ex_valid = 1 -> flush_if_id = flush_id_ex = redirect = 1 that cycle. flushed = 1 for exactly the next 2 cycles, then 0.
- In SHADOW, pc_sel_ex = 3 -> no flush, redirect = 0, shadow length unchanged at 2.
- Redirect, then stall = 1 for 3 cycles in SHADOW -> flushed stays 1 for 3 + 2 = 5 cycles total after the redirect.
- intr pulse 1 cycle with mie = 1, ex_valid = 0 for 4 cycles, then ex_valid = 1 -> int_taken = 1 on the first ex_valid cycle, then in_isr = 1. A second intr is not taken until mret_ex in RUN clears in_isr.
- int_taken and pc_sel_ex = 2 in the same cycle -> single redirect, one 2-cycle shadow. With REDIRECT_PERF_EN: redirect_cnt +1, int_cnt +1.
- RST asserted mid-SHADOW with pend_q = 1 -> next cycle flushed = 0, in_isr = 0, int_taken never asserts without a new intr.
